phys_tag_free_list: RTL and testbench
=====================================

# phys_tag_free_list

Circular free list of physical register tags for the rename stage of the out-of-order core. Hands one free tag per cycle to rename for a new destination mapping. Takes back up to two tags per cycle from the reorder buffer's retire port, which are the stale tags released at retirement. It owns the pool of tags not currently mapped to an architectural register. It is the receiving end of the ROB retire-tag interface.

## Interface
Parameters:
- NUM_PREGS, 64: total physical tags; tag width is $clog2(NUM_PREGS) = 6.
- NUM_AREGS, 32: architectural registers. Tags 0..NUM_AREGS-1 are identity-mapped at reset and are not in the list.
- DEPTH, NUM_PREGS-NUM_AREGS = 32: list capacity.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- alloc_req  in  1  rename requests a tag this cycle.
- alloc_tag  out  6  tag at list head; valid whenever empty = 0.
- alloc_grant  out  1  alloc_req & ~empty; head pops at next edge.
- free_tag [0:1]  in  6 each  stale tags from ROB retire.
- free_valid  in  2  per-slot valid; bit 0 corresponds to free_tag[0].
- free_count  out  6  number of tags in list (0..DEPTH).
- empty  out  1  free_count == 0.
- overflow_err  out  1  sticky; a free was dropped because the list was full.
- dup_err  out  1  sticky; a tag already in the list was freed. Active only with FREE_LIST_CHECK_EN.

## Operation
- Storage: DEPTH-entry array of 6-bit tags, a 5-bit head, a 5-bit tail, and a 6-bit count. Pointers wrap modulo DEPTH.
- Reset (rst low, asynchronous):
  - entry[i] = NUM_AREGS + i; head = tail = 0; count = DEPTH.
  - Resulting outputs: alloc_tag = 32, alloc_grant = 0 (tracks alloc_req), free_count = 32, empty = 0, overflow_err = 0, dup_err = 0.
- Allocate: on alloc_grant, head <= head+1 at the edge. alloc_tag is a combinational read of entry[head].
- Free:
  - Each valid slot whose tag is >= NUM_AREGS is appended at tail, slot 0 before slot 1.
  - Tags < NUM_AREGS, including x0's tag 0, are silently ignored. They are not counted and not flagged.
  - Tail advances by the number of accepted frees (0, 1 or 2).
- Capacity: free space this cycle is DEPTH - count + alloc_grant. Frees are accepted in slot order up to that limit. Excess frees are dropped and set overflow_err.
- Count: count_next = count - alloc_grant + accepted.
- Simultaneous alloc and free:
  - Both occur in the same cycle.
  - No bypass: when empty = 1, a same-cycle free does not produce a grant.
  - When count = 1 with one alloc and one free, the list stays at count 1 and the freed tag becomes head.
- Sticky errors clear only on reset.

## Timing
- Grant is combinational in the same cycle as alloc_req; the tag is consumed at that cycle's edge.
- A freed tag is written at the edge. It is visible on alloc_tag no earlier than the next cycle, and only once it reaches head.
- Back-to-back grants are allowed every cycle while empty = 0.
- Throughput: 1 alloc + 2 frees per cycle.
- Reset asserted mid-operation immediately restores the reset contents. In-flight requests that cycle are discarded.

## Configuration
- FREE_LIST_CHECK_EN defined:
  - Adds a NUM_PREGS-bit in-list bitmap: set on accepted free, cleared on grant. Bits NUM_AREGS..NUM_PREGS-1 are set at reset.
  - Freeing a tag whose bit is already set, including both slots carrying the same tag in one cycle, drops that free and sets dup_err.
- Undefined: no bitmap; dup_err is tied to 0; duplicate frees are appended as normal.

## Test plan
- Reset, then alloc_req held high for 32 cycles: alloc_tag = 32, 33, …, 63 on successive grants. Then empty = 1, alloc_grant = 0, free_count = 0.
- From empty, free_tag = {40, 45} with free_valid = 2'b11: next cycle free_count = 2 and alloc_tag = 40. After one grant, alloc_tag = 45.
- From the full reset state, free_tag[0] = 50 with free_valid = 2'b01 and no alloc: tag dropped, overflow_err = 1, free_count = 32. The same free with alloc_req = 1: accepted, free_count = 32, no error.
- With count = 1 (head = 63), alloc_req = 1 together with free 33: grant returns 63; next cycle alloc_tag = 33 and free_count = 1.
- Free tag 0 and tag 5 with free_valid = 2'b11: both ignored, free_count unchanged, no error flags.
- With FREE_LIST_CHECK_EN after reset, alloc one tag (32), then free 33 (still in list): dup_err = 1, free_count = 31. Then free 32: accepted, free_count = 32.

Source files
------------

// File: rtl/phys_tag_free_list.sv
// phys_tag_free_list: circular free list of physical register tags for rename.
// Pops one tag per cycle to rename and takes back up to two stale tags per
// cycle from the ROB retire port. Tags below NUM_AREGS are never listed.
// Optional feature: define FREE_LIST_CHECK_EN to add the in-list bitmap that
// drops and flags duplicate frees (dup_err); otherwise dup_err is tied low.
module phys_tag_free_list #(
  parameter int unsigned NUM_PREGS = 64,
  parameter int unsigned NUM_AREGS = 32,
  parameter int unsigned DEPTH     = NUM_PREGS - NUM_AREGS,
  localparam int unsigned TAG_W    = $clog2(NUM_PREGS),
  localparam int unsigned PTR_W    = $clog2(DEPTH),
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_req,
  output logic [TAG_W-1:0] alloc_tag,
  output logic             alloc_grant,
  input  logic [TAG_W-1:0] free_tag [0:1],
  input  logic [1:0]       free_valid,
  output logic [CNT_W-1:0] free_count,
  output logic             empty,
  output logic             overflow_err,
  output logic             dup_err
);

  localparam logic [TAG_W-1:0] AREG_LIM  = TAG_W'(NUM_AREGS);
  localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);

  logic [TAG_W-1:0] entry [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic             real0, real1;
  logic             dup0, dup1;
  logic             elig0, elig1;
  logic             acc0, acc1;
  logic [CNT_W:0]   space;
  logic [CNT_W:0]   space_after0;
  logic [PTR_W-1:0] wr_ptr1;
  logic [PTR_W-1:0] tail_next;
  logic [CNT_W-1:0] count_next;
  logic             ovf_hit;
  logic             dup_hit;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty       = (count == '0);
  assign alloc_grant = alloc_req & ~empty;
  assign alloc_tag   = entry[head];
  assign free_count  = count;

  // Slots carrying a real (non-identity) tag; low tags are silently ignored.
  assign real0 = free_valid[0] & (free_tag[0] >= AREG_LIM);
  assign real1 = free_valid[1] & (free_tag[1] >= AREG_LIM);

`ifdef FREE_LIST_CHECK_EN
  logic [NUM_PREGS-1:0] in_list;

  // Slot 1 is also a duplicate when slot 0 is accepted with the same tag.
  always_comb begin
    dup0 = in_list[free_tag[0]];
    dup1 = in_list[free_tag[1]] | (acc0 & (free_tag[0] == free_tag[1]));
  end

  // In-list bitmap: grant clears the head tag, accepted frees set theirs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_PREGS; i++)
        in_list[i] <= (i >= NUM_AREGS);
    end else begin
      if (alloc_grant) in_list[alloc_tag] <= 1'b0;
      if (acc0)        in_list[free_tag[0]] <= 1'b1;
      if (acc1)        in_list[free_tag[1]] <= 1'b1;
    end
  end
`else
  assign dup0 = 1'b0;
  assign dup1 = 1'b0;
`endif

  // Free acceptance in slot order against this cycle's space (including the pop).
  always_comb begin
    elig0        = real0 & ~dup0;
    elig1        = real1 & ~dup1;
    space        = DEPTH_EXT - {1'b0, count} + (CNT_W + 1)'(alloc_grant);
    acc0         = elig0 & (space != '0);
    space_after0 = space - (CNT_W + 1)'(acc0);
    acc1         = elig1 & (space_after0 != '0);
    ovf_hit      = (elig0 & ~acc0) | (elig1 & ~acc1);
    dup_hit      = (real0 & dup0) | (real1 & dup1);
    wr_ptr1      = acc0 ? ptr_inc(tail) : tail;
    tail_next    = acc1 ? ptr_inc(wr_ptr1) : wr_ptr1;
    count_next   = count - CNT_W'(alloc_grant) + CNT_W'(acc0) + CNT_W'(acc1);
  end

  // Tag storage and pointers; reset reloads tags NUM_AREGS..NUM_PREGS-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        entry[i] <= TAG_W'(NUM_AREGS + i);
      head  <= '0;
      tail  <= '0;
      count <= CNT_W'(DEPTH);
    end else begin
      if (acc0) entry[tail]    <= free_tag[0];
      if (acc1) entry[wr_ptr1] <= free_tag[1];
      if (alloc_grant) head <= ptr_inc(head);
      tail  <= tail_next;
      count <= count_next;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_err <= 1'b0;
      dup_err      <= 1'b0;
    end else begin
      if (ovf_hit) overflow_err <= 1'b1;
      if (dup_hit) dup_err      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_phys_tag_free_list.sv
// Directed bench for phys_tag_free_list with hand-computed expectations.
module tb_phys_tag_free_list;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_req;
  logic [5:0] alloc_tag;
  logic       alloc_grant;
  logic [5:0] free_tag [0:1];
  logic [1:0] free_valid;
  logic [5:0] free_count;
  logic       empty;
  logic       overflow_err;
  logic       dup_err;

  int checks = 0;
  int errors = 0;

  phys_tag_free_list #(.NUM_PREGS(64), .NUM_AREGS(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_req    (alloc_req),
    .alloc_tag    (alloc_tag),
    .alloc_grant  (alloc_grant),
    .free_tag     (free_tag),
    .free_valid   (free_valid),
    .free_count   (free_count),
    .empty        (empty),
    .overflow_err (overflow_err),
    .dup_err      (dup_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_req     = 1'b0;
    free_valid    = 2'b00;
    free_tag[0]   = '0;
    free_tag[1]   = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    #2;
    step();
    rst = 1'b1;
    #1;
  endtask

  task automatic do_free(input int t0, input int t1, input logic [1:0] v);
    free_tag[0] = 6'(t0);
    free_tag[1] = 6'(t1);
    free_valid  = v;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #3;
    do_reset();

    // Reset state
    check("rst_tag", alloc_tag, 32);
    check("rst_grant", alloc_grant, 0);
    check("rst_count", free_count, 32);
    check("rst_empty", empty, 0);
    check("rst_ovf", overflow_err, 0);
    check("rst_dup", dup_err, 0);

    // Drain all 32 tags back to back
    alloc_req = 1'b1;
    for (int i = 0; i < 32; i++) begin
      #1;
      check("drain_tag", alloc_tag, 32 + i);
      check("drain_grant", alloc_grant, 1);
      step();
    end
    #1;
    check("drain_empty", empty, 1);
    check("drain_nogrant", alloc_grant, 0);
    check("drain_count", free_count, 0);

    // No bypass: free while empty with alloc_req high gives no grant
    do_free(40, 45, 2'b11);
    #1;
    check("nobypass_grant", alloc_grant, 0);
    step();
    idle();
    #1;
    check("refill_count", free_count, 2);
    check("refill_tag", alloc_tag, 40);
    alloc_req = 1'b1;
    #1;
    check("refill_grant", alloc_grant, 1);
    step();
    alloc_req = 1'b0;
    #1;
    check("refill_tag2", alloc_tag, 45);
    check("refill_count2", free_count, 1);
    check("refill_ovf", overflow_err, 0);

    // Count 1 with head 63: alloc + free 33 together
    do_reset();
    alloc_req = 1'b1;
    for (int i = 0; i < 31; i++) step();
    #1;
    check("c1_count", free_count, 1);
    check("c1_tag", alloc_tag, 63);
    do_free(33, 0, 2'b01);
    #1;
    check("c1_grant", alloc_grant, 1);
    step();
    idle();
    #1;
    check("c1_newtag", alloc_tag, 33);
    check("c1_newcount", free_count, 1);
    check("c1_ovf", overflow_err, 0);

    // Full list: free without alloc overflows
    do_reset();
    do_free(50, 0, 2'b01);
    step();
    idle();
    #1;
    check("full_ovf", overflow_err, 1);
    check("full_count", free_count, 32);
    check("full_tag", alloc_tag, 32);

    // Full list: free with alloc is accepted, 50 lands after tag 63
    do_reset();
    alloc_req = 1'b1;
    do_free(50, 0, 2'b01);
    step();
    idle();
    #1;
    check("fullalloc_ovf", overflow_err, 0);
    check("fullalloc_count", free_count, 32);
    check("fullalloc_tag", alloc_tag, 33);
    alloc_req = 1'b1;
    for (int i = 0; i < 31; i++) step();
    alloc_req = 1'b0;
    #1;
    check("fullalloc_wrap", alloc_tag, 50);
    check("fullalloc_cnt1", free_count, 1);

    // Identity tags (0 and 5) are ignored even when the list is full
    do_reset();
    do_free(0, 5, 2'b11);
    step();
    idle();
    #1;
    check("low_count", free_count, 32);
    check("low_ovf", overflow_err, 0);
    check("low_dup", dup_err, 0);

    // Partial overflow: one slot of space, two frees -> slot 0 taken
    do_reset();
    alloc_req = 1'b1;
    step();
    alloc_req = 1'b0;
    do_free(40, 41, 2'b11);
    step();
    idle();
    #1;
    check("part_count", free_count, 32);
    check("part_ovf", overflow_err, 1);

    // Mid-operation asynchronous reset restores contents immediately
    alloc_req = 1'b1;
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    check("async_tag", alloc_tag, 32);
    check("async_count", free_count, 32);
    check("async_ovf", overflow_err, 0);
    check("async_grant_stop", int'(dut.head), 0);
    idle();
    step();
    rst = 1'b1;
    #1;

    // Duplicate free of a tag still in the list
    do_reset();
    alloc_req = 1'b1;
    step();
    alloc_req = 1'b0;
    do_free(33, 0, 2'b01);
    step();
    idle();
    #1;
`ifdef FREE_LIST_CHECK_EN
    check("dup_flag", dup_err, 1);
    check("dup_count", free_count, 31);
    do_free(32, 0, 2'b01);
    step();
    idle();
    #1;
    check("dup_refree_count", free_count, 32);
    check("dup_refree_ovf", overflow_err, 0);
`else
    check("nodup_flag", dup_err, 0);
    check("nodup_count", free_count, 32);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1);
  end

endmodule
